// File: rtl/alu4_wide_seq.sv
// Multi-cycle sequencer driving a 4-bit ALU slice over NIBBLES nibbles.
// It chains the math and rotate carries between nibbles and assembles the wide result.
module alu4_wide_seq #(
   parameter int          NIBBLES   = 4,
   parameter logic [15:0] RIGHT_OPS = 16'hA080
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   start,
   input  logic [3:0]             op,
   input  logic [4*NIBBLES-1:0]   a,
   input  logic [4*NIBBLES-1:0]   b,
   input  logic                   carry_in,
   input  logic                   rot_in,
   output logic                   busy,
   output logic                   done,
   output logic [4*NIBBLES-1:0]   result,
   output logic                   carry_out,
   output logic                   rot_carry_out,
   output logic                   zero,
   output logic                   overflow,
   output logic [3:0]             alu_op,
   output logic [3:0]             alu_a,
   output logic [3:0]             alu_b,
   output logic                   alu_cin,
   output logic                   alu_rin,
   input  logic [3:0]             alu_y,
   input  logic                   alu_cout,
   input  logic                   alu_rout,
   input  logic                   alu_ovf
);

   localparam int W  = 4 * NIBBLES;
   localparam int IW = $clog2(NIBBLES);
   localparam logic [IW-1:0] LAST = IW'(NIBBLES - 1);

   typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

   state_t        state;
   logic [W-1:0]  a_r, b_r;
   logic [IW-1:0] idx, cnt;
   logic          dir_r;

   logic [IW-1:0] step_idx, first_idx;
   logic [W-1:0]  acc_nxt;

   always_comb begin
      step_idx  = dir_r ? (idx - IW'(1)) : (idx + IW'(1));
      first_idx = RIGHT_OPS[op] ? LAST : '0;
      acc_nxt   = result;
      acc_nxt[{idx, 2'b00} +: 4] = alu_y;
   end

   // alu_cin/alu_rin double as the chain registers (cc/rc); alu_* are loaded one
   // edge ahead so the registered outputs always present the current idx nibble.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state         <= S_IDLE;
         a_r           <= '0;
         b_r           <= '0;
         idx           <= '0;
         cnt           <= '0;
         dir_r         <= 1'b0;
         busy          <= 1'b0;
         done          <= 1'b0;
         result        <= '0;
         carry_out     <= 1'b0;
         rot_carry_out <= 1'b0;
         zero          <= 1'b1;
         overflow      <= 1'b0;
         alu_op        <= '0;
         alu_a         <= '0;
         alu_b         <= '0;
         alu_cin       <= 1'b0;
         alu_rin       <= 1'b0;
      end else begin
         done <= 1'b0;
         case (state)
            S_IDLE, S_DONE: begin
               if (start) begin
                  a_r     <= a;
                  b_r     <= b;
                  idx     <= first_idx;
                  cnt     <= '0;
                  dir_r   <= RIGHT_OPS[op];
                  result  <= '0;
                  busy    <= 1'b1;
                  alu_op  <= op;
                  alu_a   <= a[{first_idx, 2'b00} +: 4];
                  alu_b   <= b[{first_idx, 2'b00} +: 4];
                  alu_cin <= carry_in;
                  alu_rin <= rot_in;
                  state   <= S_RUN;
               end else begin
                  state <= S_IDLE;
               end
            end
            S_RUN: begin
               result <= acc_nxt;
               if (idx == LAST) overflow <= alu_ovf;
               if (cnt == LAST) begin
                  state         <= S_DONE;
                  busy          <= 1'b0;
                  done          <= 1'b1;
                  carry_out     <= alu_cout;
                  rot_carry_out <= alu_rout;
                  zero          <= (acc_nxt == '0);
                  alu_op        <= '0;
                  alu_a         <= '0;
                  alu_b         <= '0;
                  alu_cin       <= 1'b0;
                  alu_rin       <= 1'b0;
               end else begin
                  cnt     <= cnt + IW'(1);
                  idx     <= step_idx;
                  alu_a   <= a_r[{step_idx, 2'b00} +: 4];
                  alu_b   <= b_r[{step_idx, 2'b00} +: 4];
                  alu_cin <= alu_cout;
                  alu_rin <= alu_rout;
               end
            end
            default: state <= S_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_alu4_wide_seq.sv
// Bench for alu4_wide_seq with a nibble ALU stub and a whole-word reference model.
// Table vectors, hand-written handshake/reset sequences, then random operations.
module tb_alu4_wide_seq;

   logic        clk = 1'b0;
   logic        rst;
   logic        start;
   logic [3:0]  op;
   logic [15:0] a, b;
   logic        carry_in, rot_in;
   logic        busy, done;
   logic [15:0] result;
   logic        carry_out, rot_carry_out, zero, overflow;
   logic [3:0]  alu_op, alu_a, alu_b, alu_y;
   logic        alu_cin, alu_rin, alu_cout, alu_rout, alu_ovf;

   int total = 0;
   int bad   = 0;

   always #5 clk = ~clk;

   alu4_wide_seq #(.NIBBLES(4), .RIGHT_OPS(16'hA080)) dut (
      .clk(clk), .rst(rst), .start(start), .op(op), .a(a), .b(b),
      .carry_in(carry_in), .rot_in(rot_in), .busy(busy), .done(done),
      .result(result), .carry_out(carry_out), .rot_carry_out(rot_carry_out),
      .zero(zero), .overflow(overflow), .alu_op(alu_op), .alu_a(alu_a),
      .alu_b(alu_b), .alu_cin(alu_cin), .alu_rin(alu_rin), .alu_y(alu_y),
      .alu_cout(alu_cout), .alu_rout(alu_rout), .alu_ovf(alu_ovf)
   );

   // ALU stub: 0 = add, D = shift right through rotate carry, 6 = xor
   logic [4:0] nsum;
   always_comb begin
      nsum     = {1'b0, alu_a} + {1'b0, alu_b} + {4'b0, alu_cin};
      alu_y    = 4'h0;
      alu_cout = 1'b0;
      alu_rout = 1'b0;
      alu_ovf  = 1'b0;
      case (alu_op)
         4'h0: begin
            alu_y    = nsum[3:0];
            alu_cout = nsum[4];
            alu_ovf  = (alu_a[3] == alu_b[3]) && (nsum[3] != alu_a[3]);
         end
         4'hD: begin
            alu_y    = {alu_rin, alu_a[3:1]};
            alu_rout = alu_a[0];
         end
         4'h6: alu_y = alu_a ^ alu_b;
         default: ;
      endcase
   end

   typedef struct packed {
      logic [15:0] res;
      logic        cout;
      logic        rout;
      logic        zero;
      logic        ovf;
   } exp_t;

   typedef struct {
      logic [3:0]  op;
      logic [15:0] a, b;
      logic        ci, ri;
      exp_t        e;
   } vec_t;

   // Whole-word view of each operation
   function automatic exp_t model(input logic [3:0] o, input logic [15:0] va, vb,
                                  input logic ci, ri);
      exp_t       e;
      logic [16:0] s;
      e = '0;
      case (o)
         4'h0: begin
            s      = {1'b0, va} + {1'b0, vb} + {16'b0, ci};
            e.res  = s[15:0];
            e.cout = s[16];
            e.ovf  = (va[15] == vb[15]) && (s[15] != va[15]);
         end
         4'hD: begin
            e.res  = {ri, va[15:1]};
            e.rout = va[0];
         end
         4'h6: e.res = va ^ vb;
         default: ;
      endcase
      e.zero = (e.res == 16'h0);
      return e;
   endfunction

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic check_result(input string tag, input exp_t e);
      check({tag, " done"},   {31'b0, done},   32'd1);
      check({tag, " busy"},   {31'b0, busy},   32'd0);
      check({tag, " result"}, {16'b0, result}, {16'b0, e.res});
      check({tag, " flags"},  {28'b0, carry_out, rot_carry_out, zero, overflow},
            {28'b0, e.cout, e.rout, e.zero, e.ovf});
   endtask

   task automatic run_op(input string tag, input logic [3:0] o, input logic [15:0] va, vb,
                         input logic ci, ri, input exp_t e);
      @(negedge clk);
      op = o; a = va; b = vb; carry_in = ci; rot_in = ri; start = 1'b1;
      @(posedge clk);
      #1 start = 1'b0;
      for (int k = 1; k <= 4; k++) begin
         @(negedge clk);
         check($sformatf("%s cyc%0d busy/done", tag, k), {30'b0, busy, done}, 32'd2);
      end
      @(negedge clk);
      check_result(tag, e);
   endtask

   vec_t vecs[9];
   logic [3:0] seq_exp[4];

   initial begin
      vecs[0] = '{op:4'h0, a:16'h0FFF, b:16'h0001, ci:1'b0, ri:1'b0, e:'{res:16'h1000, cout:1'b0, rout:1'b0, zero:1'b0, ovf:1'b0}};
      vecs[1] = '{op:4'h0, a:16'hFFFF, b:16'h0001, ci:1'b0, ri:1'b0, e:'{res:16'h0000, cout:1'b1, rout:1'b0, zero:1'b1, ovf:1'b0}};
      vecs[2] = '{op:4'h0, a:16'h7FFF, b:16'h0001, ci:1'b0, ri:1'b0, e:'{res:16'h8000, cout:1'b0, rout:1'b0, zero:1'b0, ovf:1'b1}};
      vecs[3] = '{op:4'hD, a:16'h8001, b:16'h0000, ci:1'b0, ri:1'b1, e:'{res:16'hC000, cout:1'b0, rout:1'b1, zero:1'b0, ovf:1'b0}};
      vecs[4] = '{op:4'h0, a:16'h8000, b:16'h8000, ci:1'b0, ri:1'b0, e:'{res:16'h0000, cout:1'b1, rout:1'b0, zero:1'b1, ovf:1'b1}};
      vecs[5] = '{op:4'hD, a:16'h0001, b:16'h0000, ci:1'b0, ri:1'b0, e:'{res:16'h0000, cout:1'b0, rout:1'b1, zero:1'b1, ovf:1'b0}};
      vecs[6] = '{op:4'h0, a:16'h1234, b:16'h4321, ci:1'b1, ri:1'b0, e:'{res:16'h5556, cout:1'b0, rout:1'b0, zero:1'b0, ovf:1'b0}};
      vecs[7] = '{op:4'h6, a:16'hF0F0, b:16'hF0F0, ci:1'b0, ri:1'b0, e:'{res:16'h0000, cout:1'b0, rout:1'b0, zero:1'b1, ovf:1'b0}};
      vecs[8] = '{op:4'hD, a:16'h0000, b:16'h0000, ci:1'b0, ri:1'b1, e:'{res:16'h8000, cout:1'b0, rout:1'b0, zero:1'b0, ovf:1'b0}};
      seq_exp[0] = 4'h8; seq_exp[1] = 4'h0; seq_exp[2] = 4'h0; seq_exp[3] = 4'h1;

      rst = 1'b1; start = 1'b0; op = '0; a = '0; b = '0; carry_in = 1'b0; rot_in = 1'b0;
      repeat (3) @(negedge clk);
      check("reset busy/done", {30'b0, busy, done}, 32'd0);
      check("reset result", {16'b0, result}, 32'd0);
      check("reset flags", {28'b0, carry_out, rot_carry_out, zero, overflow}, 32'b0010);
      check("reset alu", {18'b0, alu_op, alu_a, alu_b, alu_cin, alu_rin}, 32'd0);
      rst = 1'b0;

      for (int i = 0; i < 9; i++)
         run_op($sformatf("vec%0d", i), vecs[i].op, vecs[i].a, vecs[i].b,
                vecs[i].ci, vecs[i].ri, vecs[i].e);

      // MSB-first issue order for a right shift, and idle ALU drive afterwards
      @(negedge clk);
      op = 4'hD; a = 16'h8001; b = 16'h0000; carry_in = 1'b0; rot_in = 1'b1; start = 1'b1;
      @(posedge clk);
      #1 start = 1'b0;
      for (int k = 0; k < 4; k++) begin
         @(negedge clk);
         check($sformatf("shr alu_a cyc%0d", k + 1), {28'b0, alu_a}, {28'b0, seq_exp[k]});
         if (k == 0) check("shr alu_op/rin cyc1", {27'b0, alu_op, alu_rin}, {27'b0, 4'hD, 1'b1});
      end
      @(negedge clk);
      check_result("shr", model(4'hD, 16'h8001, 16'h0000, 1'b0, 1'b1));
      check("shr idle alu", {18'b0, alu_op, alu_a, alu_b, alu_cin, alu_rin}, 32'd0);

      // Handshake: start held through RUN, then accepted again in the DONE cycle
      @(negedge clk);
      op = 4'h0; a = 16'h0FFF; b = 16'h0001; carry_in = 1'b0; rot_in = 1'b0; start = 1'b1;
      @(posedge clk);
      #1 op = 4'hD; a = 16'hFFFF; b = 16'hFFFF; rot_in = 1'b0;
      for (int k = 1; k <= 4; k++) begin
         @(negedge clk);
         check($sformatf("hs cyc%0d busy/done", k), {30'b0, busy, done}, 32'd2);
      end
      @(negedge clk);
      check_result("hs first", vecs[0].e);
      @(negedge clk);
      check("hs b2b busy/done", {30'b0, busy, done}, 32'd2);
      start = 1'b0;
      repeat (3) @(negedge clk);
      check("hs b2b busy late", {31'b0, busy}, 32'd1);
      @(negedge clk);
      check_result("hs second", model(4'hD, 16'hFFFF, 16'hFFFF, 1'b0, 1'b0));

      // Reset in the second RUN cycle abandons the operation
      @(negedge clk);
      op = 4'h0; a = 16'h1111; b = 16'h1111; carry_in = 1'b0; rot_in = 1'b0; start = 1'b1;
      @(posedge clk);
      #1 start = 1'b0;
      @(negedge clk);
      @(negedge clk);
      rst = 1'b1;
      #1;
      check("rst mid busy/done", {30'b0, busy, done}, 32'd0);
      check("rst mid result", {16'b0, result}, 32'd0);
      check("rst mid flags", {28'b0, carry_out, rot_carry_out, zero, overflow}, 32'b0010);
      check("rst mid alu", {18'b0, alu_op, alu_a, alu_b, alu_cin, alu_rin}, 32'd0);
      @(negedge clk);
      rst = 1'b0;
      for (int k = 0; k < 6; k++) begin
         @(negedge clk);
         check($sformatf("rst no done %0d", k), {30'b0, busy, done}, 32'd0);
      end
      run_op("post rst", vecs[6].op, vecs[6].a, vecs[6].b, vecs[6].ci, vecs[6].ri, vecs[6].e);

      // Random operations against the whole-word model
      for (int i = 0; i < 30; i++) begin
         logic [3:0]  ro;
         logic [15:0] ra, rb;
         logic        rc, rr;
         case ($urandom_range(0, 2))
            0: ro = 4'h0;
            1: ro = 4'hD;
            default: ro = 4'h6;
         endcase
         ra = 16'($urandom);
         rb = 16'($urandom);
         rc = 1'($urandom);
         rr = 1'($urandom);
         run_op($sformatf("rand%0d op%h a%h b%h", i, ro, ra, rb), ro, ra, rb, rc, rr,
                model(ro, ra, rb, rc, rr));
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
